// File: rtl/serial_sync_tx_pkg.sv
// Shared state encoding, sync pattern and frame-length helper for the
// serial_sync_tx transmitter and its shift-register sub-block.
package serial_sync_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [2:0] SYNC_PATTERN = 3'b101;
  localparam int         SYNC_LEN     = 3;

  function automatic int frame_len(input int data_w, input bit parity_en);
    return SYNC_LEN + data_w + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/serial_sync_tx_if.sv
// Producer-side handshake plus serial line/status bundle of serial_sync_tx.
// The master modport is the word producer/observer; slave is the transmitter.
interface serial_sync_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              out;
  logic              busy;
  logic              done;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out,
    input  busy,
    input  done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_sync_tx_shreg.sv
// Loadable MSB-first shift register; zeros enter at the bottom so the line
// falls to 0 on its own once every loaded bit has been shifted out.
module serial_sync_shreg #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_shift,
  output logic         o_msb
);

  logic [W-1:0] r_shreg;
  logic [W-1:0] w_shifted;

  assign w_shifted[0] = 1'b0;
  for (genvar gi = 1; gi < W; gi++) begin : g_shift
    assign w_shifted[gi] = r_shreg[gi-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= w_shifted;
    end
  end

  assign o_msb = r_shreg[W-1];

endmodule

// File: rtl/serial_sync_tx.sv
// Serial frame transmitter: sends 1,0,1, payload MSB-first, optional even parity
// (enabled by defining SERIAL_SYNC_TX_PARITY_EN), then holds the line low for GAP cycles.
module serial_sync_tx
  import serial_sync_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic            clk,
  input  logic            reset,
  serial_sync_tx_if.slave bus
);

`ifdef SERIAL_SYNC_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int L   = frame_len(DATA_W, PARITY_EN);
  localparam int BCW = $clog2(L + 1);
  localparam int GCW = $clog2(GAP + 1);

  localparam logic [BCW-1:0] BIT_LAST = BCW'(L - 1);
  localparam logic [BCW-1:0] BIT_END  = BCW'(L);
  localparam logic [GCW-1:0] GAP_END  = GCW'(GAP);

  state_t         r_state;
  state_t         w_state_next;
  logic [BCW-1:0] r_bit_cnt;
  logic [GCW-1:0] r_gap_cnt;
  logic           r_in_ready;
  logic           r_done;

  logic           w_handshake;
  logic           w_load;
  logic           w_shift;
  logic           w_busy;
  logic           w_in_ready_next;
  logic           w_done_next;
  logic           w_line;
  logic [L-1:0]   w_frame;

  // First bit on the wire is the MSB of the frame vector.
`ifdef SERIAL_SYNC_TX_PARITY_EN
  assign w_frame = {SYNC_PATTERN, bus.in_data, ^bus.in_data};
`else
  assign w_frame = {SYNC_PATTERN, bus.in_data};
`endif

  assign w_handshake = bus.in_valid && r_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_handshake)          w_state_next = S_FRAME;
      S_FRAME: if (r_bit_cnt == BIT_END) w_state_next = S_GAP;
      S_GAP:   if (r_gap_cnt == GAP_END) w_state_next = S_IDLE;
      default:                           w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load          = (r_state == S_IDLE) && w_handshake;
    w_shift         = (r_state == S_FRAME);
    w_busy          = (r_state != S_IDLE);
    w_in_ready_next = (w_state_next == S_IDLE);
    w_done_next     = (r_state == S_FRAME) && (r_bit_cnt == BIT_LAST);
  end

  // r_bit_cnt counts bits already placed on the line; the load itself places bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_next;
      r_done     <= w_done_next;

      if (w_load) begin
        r_bit_cnt <= BCW'(1);
      end else if (w_shift) begin
        r_bit_cnt <= (r_bit_cnt == BIT_END) ? '0 : r_bit_cnt + BCW'(1);
      end

      if ((r_state == S_FRAME) && (w_state_next == S_GAP)) begin
        r_gap_cnt <= GCW'(1);
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= (r_gap_cnt == GAP_END) ? '0 : r_gap_cnt + GCW'(1);
      end
    end
  end

  serial_sync_shreg #(
    .W (L)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (w_frame),
    .i_shift (w_shift),
    .o_msb   (w_line)
  );

  assign bus.out      = w_line;
  assign bus.busy     = w_busy;
  assign bus.in_ready = r_in_ready;
  assign bus.done     = r_done;

endmodule

// File: doc/serial_sync_tx.md
# serial_sync_tx

Serial frame transmitter that produces the one-wire bitstream consumed by the team's `101` sync-pattern detector FSMs. Each parallel word accepted on a valid/ready input is sent as the sync pattern `1,0,1`, then the payload MSB-first, then an optional even-parity bit. The line is then held low for a programmable idle gap. It sits between a word-producing datapath and the serial link pin.

## Interface
- `DATA_W`, default 8: payload width in bits. Minimum 1.
- `GAP`, default 2: number of forced-low cycles after each frame. Minimum 1.
- `clk`  input  1  sole clock. All state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `in_data`  input  DATA_W  payload word. Sampled only on handshake.
- `in_valid`  input  1  producer has a word.
- `in_ready`  output  1  registered. High only in IDLE.
- `out`  output  1  registered serial line. Idle level 0.
- `busy`  output  1  high in FRAME or GAP.
- `done`  output  1  registered. One-cycle pulse during the cycle the last frame bit is on `out`.

## Operation
- States:
  - IDLE: `out`=0, `in_ready`=1.
  - FRAME: shifting out the frame.
  - GAP: `out`=0, counting GAP cycles.
- Frame length L = 3 + DATA_W (+1 with parity). Frame bits are {1,0,1, in_data[DATA_W-1:0] MSB first, [parity]}.
- IDLE -> FRAME:
  - Occurs on an edge with `in_valid && in_ready`.
  - Shift register loads the full frame.
  - `out` takes frame bit 0 at that same edge.
- FRAME:
  - Each edge shifts one bit.
  - A bit counter of width $clog2(L+1) tracks position.
  - After L bits: FRAME -> GAP, `out`=0.
- GAP:
  - A counter of width $clog2(GAP+1) runs for GAP cycles.
  - Then GAP -> IDLE, `in_ready`=1.
- `in_valid` outside IDLE is ignored. Changes to `in_data` after the handshake do not affect the frame in flight.
- The payload may itself contain `101`. This is legal: the receiver counts bits after sync.

## Timing
- Reset (asynchronous, immediate) forces:
  - state=IDLE
  - `out`=0, `in_ready`=0, `busy`=0, `done`=0
  - shift register and counters cleared
- First edge after reset release: `in_ready`=1.
- Reset mid-frame or mid-gap: the frame is abandoned. No partial resume.
- Latency: handshake at edge E0. Bit k is on `out` for the cycle after edge E0+k, for k=0..L-1.
- Edge E0+L:
  - `out`=0
  - `busy` stays 1
  - `done` falls; it was high for the bit L-1 cycle
- Edge E0+L+GAP: `in_ready`=1, `busy`=0.
- Earliest next handshake is edge E0+L+GAP+1. Back-to-back period is L+GAP+1 cycles.
- `busy` rises at edge E0, together with `out`.

## Configuration
- `SERIAL_SYNC_TX_PARITY_EN`:
  - Defined: an even-parity bit (XOR of `in_data`) is appended as the last frame bit, and L = DATA_W+4.
  - Undefined: no parity bit, and L = DATA_W+3.
- The macro changes nothing else.

## Structure
- Package `serial_sync_pkg` holds:
  - state enum {IDLE, FRAME, GAP}
  - `SYNC_PATTERN` = 3'b101
  - `SYNC_LEN` = 3
  - the frame-length function of DATA_W and the parity setting
- Sub-module `serial_sync_shreg`: a loadable MSB-first shift register of width L with a parallel load and a shift-enable. The top level keeps the FSM, counters and handshake.

## Test plan
All scenarios use DATA_W=8 and GAP=2.
- Reset release, `in_valid`=0 -> `out`=0, `busy`=0, and `in_ready` rises one edge after release and stays high.
- Single word 0xA5, parity off -> `out` = 1,0,1,1,0,1,0,0,1,0,1, then 0 for 2 cycles. `done` is high only on the 11th bit. `in_ready` returns at handshake+13.
- 0xA5 then 0x07 with `in_valid` held high, parity on:
  - 0xA5 parity bit is 0; frames start 15 cycles apart.
  - 0x07 frame ends with parity bit 1.
- `in_data` toggled every cycle during a 0x3C frame -> the serialized payload is still 0,0,1,1,1,1,0,0.
- Reset asserted at bit 5 of a frame -> `out`=0 immediately with no clock edge needed. After release, the next word is sent as a complete frame starting with 1,0,1.
- Payload 0xFF, then 0x00, parity on -> payload bits all-1 with parity 0, then all-0 with parity 0. `out` stays 0 throughout the gap.
